ex_issue_ctrl: RTL and testbench

- Pipeline controller that sequences instruction issue from the ID/EX register into the Execute stage.
- Tracks in-flight destination registers in the EX and WB slots in a two-entry scoreboard.
- Stalls ID on read-after-write hazards and inserts EX bubbles.
- Owns the internal_reset flush sequence after reset and a halt/drain/resume protocol for the core.

---
 rtl/ex_issue_ctrl_pkg.sv | 22 ++
 rtl/ex_scoreboard.sv | 45 ++++
 rtl/ex_issue_ctrl.sv | 128 ++++++++++++
 tb/tb_ex_issue_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// ex_issue_ctrl_pkg: shared types and defaults for the EX issue controller.
package ex_issue_ctrl_pkg;

    localparam int DEFAULT_NUM_REGS     = 16;
    localparam int DEFAULT_FLUSH_CYCLES = 3;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] t_reg_addr;

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } t_ctrl_state;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EX   = 2'd1,
        FWD_WB   = 2'd2
    } t_fwd_sel;

endpackage

// File: rtl/ex_scoreboard.sv
// ex_scoreboard: EX/WB destination slots and per-operand match flags.
module ex_scoreboard #(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              issue_i,
    input  logic              wr_en_i,
    input  logic [REG_AW-1:0] dst_i,
    input  logic [REG_AW-1:0] src1_i,
    input  logic              src1_used_i,
    input  logic [REG_AW-1:0] src2_i,
    input  logic              src2_used_i,
    output logic              ex_v_o,
    output logic              wb_v_o,
    output logic              s1_ex_o,
    output logic              s1_wb_o,
    output logic              s2_ex_o,
    output logic              s2_wb_o
);

    logic              ex_v_q, wb_v_q;
    logic [REG_AW-1:0] ex_dst_q, wb_dst_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            ex_v_q <= 1'b0;
            wb_v_q <= 1'b0;
        end else begin
            ex_v_q <= issue_i & wr_en_i;
            wb_v_q <= ex_v_q;
        end
        ex_dst_q <= dst_i;
        wb_dst_q <= ex_dst_q;
    end

    assign ex_v_o  = ex_v_q;
    assign wb_v_o  = wb_v_q;
    assign s1_ex_o = src1_used_i & ex_v_q & (src1_i == ex_dst_q);
    assign s1_wb_o = src1_used_i & wb_v_q & (src1_i == wb_dst_q);
    assign s2_ex_o = src2_used_i & ex_v_q & (src2_i == ex_dst_q);
    assign s2_wb_o = src2_used_i & wb_v_q & (src2_i == wb_dst_q);

endmodule

// File: rtl/ex_issue_ctrl.sv
// ex_issue_ctrl: issue sequencing, RAW stalls, post-reset flush and halt/drain/resume.
// EX_FORWARD_EN replaces scoreboard stalls with forward selects.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter  int NUM_REGS     = DEFAULT_NUM_REGS,
    parameter  int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES,
    parameter  int CNT_W        = 16,
    localparam int REG_AW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              halt_req,
    input  logic              resume,
    output logic              internal_reset,
    output logic              stall_id,
    output logic              ex_issue,
    output logic              halted,
    output logic [1:0]        fwd_sel1,
    output logic [1:0]        fwd_sel2,
    output logic [CNT_W-1:0]  hazard_cnt
);

    t_ctrl_state      state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             internal_reset_q;
    logic [CNT_W-1:0] hazard_cnt_q;
    logic             count_hz;
    logic             hz;
    logic             ex_v, wb_v, s1_ex, s1_wb, s2_ex, s2_wb;
    t_fwd_sel         fwd1, fwd2;

    ex_scoreboard #(.REG_AW(REG_AW)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (state_q == FLUSH),
        .issue_i     (ex_issue),
        .wr_en_i     (id_wr_en),
        .dst_i       (id_dst),
        .src1_i      (id_src1),
        .src1_used_i (id_src1_used),
        .src2_i      (id_src2),
        .src2_used_i (id_src2_used),
        .ex_v_o      (ex_v),
        .wb_v_o      (wb_v),
        .s1_ex_o     (s1_ex),
        .s1_wb_o     (s1_wb),
        .s2_ex_o     (s2_ex),
        .s2_wb_o     (s2_wb)
    );

`ifdef EX_FORWARD_EN
    assign hz   = 1'b0;
    assign fwd1 = rst ? FWD_NONE : s1_ex ? FWD_EX : s1_wb ? FWD_WB : FWD_NONE;
    assign fwd2 = rst ? FWD_NONE : s2_ex ? FWD_EX : s2_wb ? FWD_WB : FWD_NONE;
`else
    assign hz   = id_valid & (s1_ex | s1_wb | s2_ex | s2_wb);
    assign fwd1 = FWD_NONE;
    assign fwd2 = FWD_NONE;
`endif

    assign fwd_sel1 = fwd1;
    assign fwd_sel2 = fwd2;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        stall_id    = 1'b1;
        ex_issue    = 1'b0;
        halted      = 1'b0;
        count_hz    = 1'b0;
        case (state_q)
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) state_d = RUN;
            end
            RUN: begin
                count_hz = hz;
                // halt wins over issue: the ID instruction stays put for after resume
                if (halt_req) begin
                    state_d = DRAIN;
                end else begin
                    ex_issue = id_valid & ~hz;
                    stall_id = hz;
                end
            end
            DRAIN: begin
                if (!ex_v && !wb_v) state_d = HALTED;
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) state_d = RUN;
            end
            default: state_d = FLUSH;
        endcase
        if (rst) begin
            stall_id = 1'b1;
            ex_issue = 1'b0;
            halted   = 1'b0;
            count_hz = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= FLUSH;
            flush_cnt_q      <= 4'(FLUSH_CYCLES);
            internal_reset_q <= 1'b1;
            hazard_cnt_q     <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            internal_reset_q <= (state_d == FLUSH);
            hazard_cnt_q     <= (count_hz && !(&hazard_cnt_q)) ? hazard_cnt_q + 1'b1 : hazard_cnt_q;
        end
    end

    assign internal_reset = internal_reset_q;
    assign hazard_cnt     = hazard_cnt_q;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb_ex_issue_ctrl: directed checks of flush, RAW stalls/forwarding, halt/resume and counter saturation.
module tb_ex_issue_ctrl;

`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_src1_used = 1'b0, id_src2_used = 1'b0, id_wr_en = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, id_dst = '0;
    logic       halt_req = 1'b0, resume = 1'b0;

    logic        internal_reset, stall_id, ex_issue, halted;
    logic [1:0]  fwd_sel1, fwd_sel2;
    logic [15:0] hazard_cnt;
    logic        ir4, stall4, iss4, halt4;
    logic [1:0]  f14, f24;
    logic [3:0]  hazard_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_issue_ctrl #(.NUM_REGS(16), .FLUSH_CYCLES(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_wr_en(id_wr_en), .id_dst(id_dst),
        .halt_req(halt_req), .resume(resume),
        .internal_reset(internal_reset), .stall_id(stall_id), .ex_issue(ex_issue),
        .halted(halted), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .hazard_cnt(hazard_cnt)
    );

    ex_issue_ctrl #(.NUM_REGS(16), .FLUSH_CYCLES(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_src1(id_src1), .id_src1_used(id_src1_used),
        .id_src2(id_src2), .id_src2_used(id_src2_used),
        .id_wr_en(id_wr_en), .id_dst(id_dst),
        .halt_req(halt_req), .resume(resume),
        .internal_reset(ir4), .stall_id(stall4), .ex_issue(iss4),
        .halted(halt4), .fwd_sel1(f14), .fwd_sel2(f24), .hazard_cnt(hazard_cnt4)
    );

    wire [3:0] ctl = {internal_reset, stall_id, ex_issue, halted};
    wire [7:0] obs = {ctl, fwd_sel1, fwd_sel2};

    task automatic drive(input logic v, input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2, input logic w, input logic [3:0] d);
        id_valid = v; id_src1 = s1; id_src1_used = u1;
        id_src2 = s2; id_src2_used = u2; id_wr_en = w; id_dst = d;
    endtask

    task automatic do_reset();
        rst = 1'b1; halt_req = 1'b0; resume = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({obs, hazard_cnt} !== {8'b1100_0000, 16'd0}) begin
            n_fail++; $display("FAIL reset_outputs obs=%b cnt=%0d exp obs=11000000 cnt=0", obs, hazard_cnt);
        end
        rst = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            exp = (c <= 3) ? 4'b1100 : 4'b0010;
            n_checks++;
            if (ctl !== exp) begin
                n_fail++; $display("FAIL flush_c%0d ctl=%b exp=%b", c, ctl, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_raw();
        logic [7:0] exp;
`ifdef EX_FORWARD_EN
        drive(1, 0, 0, 0, 0, 1, 3);
        #1; n_checks++;
        if (obs !== 8'b0010_0000) begin n_fail++; $display("FAIL fwd_writer obs=%b exp=00100000", obs); end
        @(negedge clk);
        drive(1, 3, 1, 0, 0, 0, 0);
        #1; n_checks++;
        if (obs !== 8'b0010_0100) begin n_fail++; $display("FAIL fwd_ex obs=%b exp=00100100", obs); end
        @(negedge clk);
        drive(1, 0, 0, 3, 1, 0, 0);
        #1; n_checks++;
        if (obs !== 8'b0010_0010) begin n_fail++; $display("FAIL fwd_wb obs=%b exp=00100010", obs); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 4);
        @(negedge clk);
        drive(1, 4, 1, 4, 1, 0, 0);
        #1; n_checks++;
        if (obs !== 8'b0010_0101) begin n_fail++; $display("FAIL fwd_ex_prio obs=%b exp=00100101", obs); end
        @(negedge clk);
`else
        drive(1, 0, 0, 0, 0, 1, 3);
        #1; n_checks++;
        if (obs !== 8'b0010_0000) begin n_fail++; $display("FAIL raw_writer obs=%b exp=00100000", obs); end
        @(negedge clk);
        drive(1, 3, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            exp = (c < 3) ? 8'b0100_0000 : 8'b0010_0000;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL raw_src1_c%0d obs=%b exp=%b", c, obs, exp); end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #1; n_checks++;
        if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL raw_cnt got=%0d exp=2", hazard_cnt); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 7);
        @(negedge clk);
        drive(1, 7, 0, 7, 1, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            #1;
            exp = (c < 3) ? 8'b0100_0000 : 8'b0010_0000;
            n_checks++;
            if (obs !== exp) begin n_fail++; $display("FAIL raw_src2_c%0d obs=%b exp=%b", c, obs, exp); end
            @(negedge clk);
        end
        drive(1, 0, 0, 0, 0, 0, 9);
        @(negedge clk);
        drive(1, 9, 1, 9, 1, 0, 0);
        #1; n_checks++;
        if (obs !== 8'b0010_0000) begin n_fail++; $display("FAIL no_writer obs=%b exp=00100000", obs); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 10);
        @(negedge clk);
        drive(1, 10, 0, 10, 0, 0, 0);
        #1; n_checks++;
        if (obs !== 8'b0010_0000) begin n_fail++; $display("FAIL unused_src obs=%b exp=00100000", obs); end
        @(negedge clk);
`endif
        drive(0, 0, 0, 0, 0, 0, 0);
        #1; n_checks++;
        if (hazard_cnt !== (FWD ? 16'd0 : 16'd4)) begin
            n_fail++; $display("FAIL raw_total_cnt got=%0d exp=%0d", hazard_cnt, FWD ? 0 : 4);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_halt();
        logic [3:0] exp;
        drive(1, 0, 0, 0, 0, 1, 1);
        #1; n_checks++;
        if (ctl !== 4'b0010) begin n_fail++; $display("FAIL halt_w1 ctl=%b exp=0010", ctl); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 2);
        @(negedge clk);
        halt_req = 1'b1;
        drive(1, 2, 1, 0, 0, 0, 0);
        #1; n_checks++;
        if (ctl !== 4'b0100) begin n_fail++; $display("FAIL halt_prio ctl=%b exp=0100", ctl); end
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            #1;
            exp = (c < 3) ? 4'b0100 : 4'b0101;
            n_checks++;
            if (ctl !== exp) begin n_fail++; $display("FAIL drain_c%0d ctl=%b exp=%b", c, ctl, exp); end
            @(negedge clk);
        end
        halt_req = 1'b0;
        resume   = 1'b1;
        #1; n_checks++;
        if (ctl !== 4'b0101) begin n_fail++; $display("FAIL halted_hold ctl=%b exp=0101", ctl); end
        @(negedge clk);
        resume = 1'b0;
        #1; n_checks++;
        if (ctl !== 4'b0010) begin n_fail++; $display("FAIL resume_issue ctl=%b exp=0010", ctl); end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        #1; n_checks++;
        if (ctl !== 4'b0010) begin n_fail++; $display("FAIL resume_in_run ctl=%b exp=0010", ctl); end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (hazard_cnt !== (FWD ? 16'd0 : 16'd5)) begin
            n_fail++; $display("FAIL halt_hz_cnt got=%0d exp=%0d", hazard_cnt, FWD ? 0 : 5);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_drain();
        logic [3:0] exp;
        drive(1, 0, 0, 0, 0, 1, 5);
        @(negedge clk);
        halt_req = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1; n_checks++;
        if (ctl !== 4'b0100) begin n_fail++; $display("FAIL in_drain ctl=%b exp=0100", ctl); end
        rst = 1'b1;
        halt_req = 1'b0;
        #1; n_checks++;
        if (ctl[2:0] !== 3'b100) begin n_fail++; $display("FAIL rst_override ctl=%b exp=x100", ctl); end
        @(negedge clk);
        rst = 1'b0;
        drive(1, 5, 1, 0, 0, 0, 0);
        for (int c = 1; c <= 3; c++) begin
            #1; n_checks++;
            if (ctl !== 4'b1100) begin n_fail++; $display("FAIL reflush_c%0d ctl=%b exp=1100", c, ctl); end
            @(negedge clk);
        end
        #1; n_checks++;
        if ({obs, hazard_cnt} !== {8'b0010_0000, 16'd0}) begin
            n_fail++; $display("FAIL post_reset_read obs=%b cnt=%0d exp obs=00100000 cnt=0", obs, hazard_cnt);
        end
        @(negedge clk);
        exp = 4'b0000;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1; n_checks++;
        if (ctl !== exp) begin n_fail++; $display("FAIL post_reset_idle ctl=%b exp=%b", ctl, exp); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        do_reset();
        drive(1, 3, 1, 0, 0, 1, 3);
        repeat (10) @(negedge clk);
        #1; n_checks++;
        if (hazard_cnt4 !== (FWD ? 4'd0 : 4'd6)) begin
            n_fail++; $display("FAIL sat_partial got=%0d exp=%0d", hazard_cnt4, FWD ? 0 : 6);
        end
        repeat (35) @(negedge clk);
        #1; n_checks++;
        if (hazard_cnt4 !== (FWD ? 4'd0 : 4'd15)) begin
            n_fail++; $display("FAIL sat_cnt4 got=%0d exp=%0d", hazard_cnt4, FWD ? 0 : 15);
        end
        n_checks++;
        if (hazard_cnt !== (FWD ? 16'd0 : 16'd30)) begin
            n_fail++; $display("FAIL sat_cnt16 got=%0d exp=%0d", hazard_cnt, FWD ? 0 : 30);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_raw();
        test_halt();
        test_reset_in_drain();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
